// File: rtl/time_pkg.sv
// Shared types and constants for the multiplexed HH:MM display scanner.
package time_pkg;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  // Segment patterns, {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Unrolled subtract-10 conversion; six steps cover the full 6-bit range
  function automatic bcd_t to_bcd(input logic [5:0] v);
    bcd_t       r;
    logic [5:0] rem;
    rem    = v;
    r.tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem    = rem - 6'd10;
        r.tens = r.tens + 4'd1;
      end
    end
    r.ones = 4'(rem);
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment lookup; non-BCD codes blank.
module seg7_decode
  import time_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Four-digit HH:MM multiplexed LED scanner with guard band, PWM dimming,
// leading-zero blanking and a blinking colon.
module time_display_scan
  import time_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned GUARD    = 16,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [4:0]          hour_now,
  input  logic [5:0]          min_now,
  input  logic                sec_pulse,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blank_lz,
  output logic [3:0]          an_n,
  output logic [6:0]          seg_n,
  output logic                dp_n
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);

  digit_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                colon;
  logic [4:0]          snap_hour;
  logic [5:0]          snap_min;

  logic       slot_last, active, lit, invalid, blank_d3;
  bcd_t       hour_bcd, min_bcd;
  logic [3:0] digit;
  logic [6:0] digit_seg_c;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign active    = (slot_cnt >= SLOT_W'(GUARD));
  assign lit       = (&brightness) || (pwm_cnt < brightness);
  assign hour_bcd  = to_bcd(6'(snap_hour));
  assign min_bcd   = to_bcd(snap_min);
  assign invalid   = (snap_hour > 5'(HOUR_MAX)) || (snap_min > 6'(MIN_MAX));
  assign blank_d3  = blank_lz && !invalid && (hour_bcd.tens == 4'd0);

  always_comb begin
    digit = 4'd0;
    case (state_q)
      D3:      digit = hour_bcd.tens;
      D2:      digit = hour_bcd.ones;
      D1:      digit = min_bcd.tens;
      default: digit = min_bcd.ones;
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd   (digit),
    .seg_c (digit_seg_c)
  );

  // Digit sequencing plus next-cycle output image
  always_comb begin
    state_d = state_q;
    an_d    = 4'hF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    if (slot_last) begin
      case (state_q)
        D3:      state_d = D2;
        D2:      state_d = D1;
        D1:      state_d = D0;
        default: state_d = D3;
      endcase
    end
    if (active && !(state_q == D3 && blank_d3)) begin
      an_d[2'(state_q)] = 1'b0;
      if (lit) begin
        seg_d = invalid ? SEG_DASH : digit_seg_c;
        dp_d  = !(state_q == D2 && colon);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= D3;
      slot_cnt  <= '0;
      pwm_cnt   <= '0;
      colon     <= 1'b0;
      snap_hour <= '0;
      snap_min  <= '0;
      an_n      <= 4'hF;
      seg_n     <= SEG_BLANK;
      dp_n      <= 1'b1;
    end else begin
      state_q  <= state_d;
      slot_cnt <= slot_last ? '0 : slot_cnt + SLOT_W'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      if (sec_pulse) colon <= ~colon;
      // Frame-start snapshot keeps a frame self-consistent
      if (state_q == D3 && slot_cnt == '0) begin
        snap_hour <= hour_now;
        snap_min  <= min_now;
      end
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench: per-slot expected records are queued by the stimulus and
// matched by a monitor that summarises each anode-active window.
module tb_time_display_scan;

  localparam int unsigned SCAN_DIV = 36;
  localparam int unsigned GUARD    = 4;
  localparam int unsigned PWM_BITS = 4;
  localparam int          ACT      = SCAN_DIV - GUARD;

  logic                clk = 1'b0;
  logic                rstn;
  logic [4:0]          hour_now;
  logic [5:0]          min_now;
  logic                sec_pulse;
  logic [PWM_BITS-1:0] brightness;
  logic                blank_lz;
  logic [3:0]          an_n;
  logic [6:0]          seg_n;
  logic                dp_n;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [7:0] lit;
    logic [7:0] dp;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stray   = 0;
  logic win_open = 1'b0;
  logic win_bad  = 1'b0;
  rec_t win;

  time_display_scan #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .hour_now   (hour_now),
    .min_now    (min_now),
    .sec_pulse  (sec_pulse),
    .brightness (brightness),
    .blank_lz   (blank_lz),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input int lit, input int dp);
    exp_q.push_back({an, seg, 8'(lit), 8'(dp)});
  endtask

  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input int lit, input int dp2, input bit skip3);
    if (!skip3) push(4'b0111, s3, lit, 0);
    push(4'b1011, s2, lit, dp2);
    push(4'b1101, s1, lit, 0);
    push(4'b1110, s0, lit, 0);
  endtask

  task automatic close_win();
    rec_t e;
    win_open = 1'b0;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL window: unexpected an_n=%b seg_n=%h lit=%0d dp=%0d, required none",
               win.an, win.seg, win.lit, win.dp);
    end else begin
      e = exp_q.pop_front();
      if (win != e || win_bad) begin
        n_fail++;
        $display("FAIL window: got an_n=%b seg_n=%h lit=%0d dp=%0d mixed=%0b, required an_n=%b seg_n=%h lit=%0d dp=%0d",
                 win.an, win.seg, win.lit, win.dp, win_bad, e.an, e.seg, e.lit, e.dp);
      end
    end
  endtask

  // One record per anode-active window; windows cut by reset are dropped
  task automatic monitor();
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn) begin
        win_open = 1'b0;
      end else if (an_n != 4'hF) begin
        if (win_open && an_n != win.an) close_win();
        if (!win_open) begin
          win_open = 1'b1;
          win_bad  = 1'b0;
          win      = {an_n, 7'h7F, 8'd0, 8'd0};
        end
        if (seg_n != 7'h7F) begin
          if (win.seg != 7'h7F && win.seg != seg_n) win_bad = 1'b1;
          win.seg = seg_n;
          win.lit = win.lit + 8'd1;
        end
        if (!dp_n) win.dp = win.dp + 8'd1;
      end else begin
        if (win_open) close_win();
        if (seg_n != 7'h7F || !dp_n) stray++;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rstn       = 1'b0;
    hour_now   = 5'd13;
    min_now    = 6'd7;
    sec_pulse  = 1'b0;
    brightness = 4'd15;
    blank_lz   = 1'b0;
    cyc(3);
    check("reset_an_n", 32'(an_n), 32'hF);
    check("reset_seg_n", 32'(seg_n), 32'h7F);
    check("reset_dp_n", 32'(dp_n), 32'h1);

    push_frame(7'h79, 7'h30, 7'h40, 7'h78, ACT, 0, 1'b0);      // A 13:07
    push_frame(7'h79, 7'h19, 7'h40, 7'h78, ACT, 0, 1'b0);      // B 14:07
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, ACT, 0, 1'b0);      // C 24:00 invalid
    push_frame(7'h40, 7'h12, 7'h19, 7'h24, ACT / 2, 0, 1'b0);  // D 05:42 half duty
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 0, 1'b0);        // E brightness 0
    push_frame(7'h7F, 7'h12, 7'h19, 7'h24, ACT, 0, 1'b1);      // F leading zero blanked
    push_frame(7'h79, 7'h30, 7'h40, 7'h78, ACT, ACT, 1'b0);    // G colon on
    push_frame(7'h79, 7'h30, 7'h40, 7'h78, ACT, 0, 1'b0);      // H colon off
    push(4'b0111, 7'h79, ACT, 0);                              // I, cut by reset in D1
    push(4'b1011, 7'h30, ACT, 0);

    rstn = 1'b1;
    cyc(80);
    hour_now = 5'd14;
    cyc(64);
    cyc(144);
    hour_now = 5'd24;
    min_now  = 6'd0;
    cyc(144);
    hour_now   = 5'd5;
    min_now    = 6'd42;
    brightness = 4'd8;
    cyc(144);
    brightness = 4'd0;
    cyc(144);
    brightness = 4'd15;
    blank_lz   = 1'b1;
    cyc(143);
    sec_pulse = 1'b1;
    cyc(1);
    sec_pulse = 1'b0;
    blank_lz  = 1'b0;
    hour_now  = 5'd13;
    min_now   = 6'd7;
    cyc(143);
    sec_pulse = 1'b1;
    cyc(1);
    sec_pulse = 1'b0;
    cyc(144);
    cyc(80);

    rstn = 1'b0;
    #1;
    check("midslot_reset_an_n", 32'(an_n), 32'hF);
    check("midslot_reset_seg_n", 32'(seg_n), 32'h7F);
    check("midslot_reset_dp_n", 32'(dp_n), 32'h1);
    hour_now = 5'd21;
    min_now  = 6'd59;
    cyc(3);
    push_frame(7'h24, 7'h79, 7'h12, 7'h10, ACT, 0, 1'b0);     // J 21:59
    rstn = 1'b1;
    cyc(GUARD);
    check("post_reset_guard_an_n", 32'(an_n), 32'hF);
    cyc(1);
    check("post_reset_first_an_n", 32'(an_n), 32'h7);
    cyc(141);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("no_output_in_guard", 32'(stray), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1024: clock cycles per digit slot, minimum 2*GUARD.
REQ-002 Parameter GUARD, default 16: cycles at the start of each slot with all anodes off (anti-ghosting).
REQ-003 Parameter PWM_BITS, default 4: width of the brightness PWM counter.
REQ-004 Port clk  in  1  system clock; all logic on its rising edge.
REQ-005 Port rstn  in  1  reset, asynchronous, active-low.
REQ-006 Port hour_now  in  5  current hour, binary, valid range 0..23.
REQ-007 Port min_now  in  6  current minute, binary, valid range 0..59.
REQ-008 Port sec_pulse  in  1  one-cycle pulse once per second; toggles the colon.
REQ-009 Port brightness  in  PWM_BITS  segment duty level.
REQ-010 Port blank_lz  in  1  when 1, blank the hour tens digit if it is zero.
REQ-011 Port an_n  out  4  digit anodes, active-low; [3]=hour tens, [2]=hour ones, [1]=min tens, [0]=min ones.
REQ-012 Port seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 Port dp_n  out  1  decimal point/colon, active-low.

Function
REQ-014 The digit FSM SHALL have states D3, D2, D1, D0, visited in that order, advancing when the slot counter reaches SCAN_DIV-1, and wrapping from D0 to D3.
REQ-015 On entry to D3 (frame start), hour_now/min_now SHALL be snapshotted; input changes mid-frame SHALL NOT appear before the next frame.
REQ-016 The snapshot SHALL be converted to four BCD digits by iterative subtract-10 or compare logic with no divider; result ready before D3 anode enable (within GUARD cycles).
REQ-017 If the snapshot has hour>23 or min>59, all four digits SHALL show "-" (g only, seg_n=7'h3F).
REQ-018 During slot cycles 0..GUARD-1, an_n SHALL be 4'hF; afterwards only the current digit's anode SHALL be low.
REQ-019 A free-running PWM_BITS counter SHALL gate segments: lit when pwm_cnt < brightness, or always when brightness is all ones; brightness=0 gives seg_n=7'h7F.
REQ-020 In state D3 with blank_lz=1 and hour tens=0, an_n[3] SHALL stay high for the whole slot.
REQ-021 A colon flag SHALL toggle on each sec_pulse; dp_n SHALL be low only during D2 anode-active, PWM-lit cycles with colon=1.
REQ-022 an_n, seg_n, and dp_n SHALL be registered, one cycle after the internal slot/PWM state.
REQ-023 sec_pulse coinciding with a frame wrap SHALL still toggle the colon exactly once.

Reset
REQ-024 While rstn=0: an_n=4'hF, seg_n=7'h7F, dp_n=1, FSM=D3, slot and PWM counters=0, colon=0, snapshot=0.
REQ-025 Reset mid-slot SHALL blank outputs immediately (asynchronously); after release, the first cycle SHALL start a new frame and take a fresh snapshot.

Structure
REQ-026 The package time_pkg SHALL hold the digit-state enum, segment-pattern constants (digits 0-9, dash, blank), and the 23/59 limits.
REQ-027 The BCD-to-segment lookup SHALL be a combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low segments out).

Verification
REQ-028 hour=13, min=7, brightness=15 -> successive slots seg_n=7'h79, 7'h30, 7'h40, 7'h78 with an_n=0111, 1011, 1101, 1110.
REQ-029 hour changes 13->14 during D1 -> rest of the frame shows 13; next frame's D2 shows 7'h19.
REQ-030 hour=24, min=0 -> every digit seg_n=7'h3F.
REQ-031 brightness=8 -> seg_n lit exactly 8 of every 16 anode-active cycles; brightness=0 -> seg_n=7'h7F throughout.
REQ-032 blank_lz=1, hour=5 -> an_n[3] never low; blank_lz=0 -> D3 shows 7'h40.
REQ-033 rstn pulsed low mid-D1 -> an_n=4'hF in the same cycle; after release the first active anode is an_n[3] after GUARD cycles; two sec_pulses -> dp_n low only in D2, then never.
